// File: rtl/hazard_pkg.sv
// Shared constants and types for the register hazard scoreboard.
package hazard_pkg;

    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_NUM_SRC  = 2;
    localparam int DEFAULT_REG_W    = $clog2(DEFAULT_NUM_REGS);

    // Age of a pending write: where its producer sits in the pipeline.
    localparam logic [1:0] AGE_EXE = 2'd0;
    localparam logic [1:0] AGE_MEM = 2'd1;
    localparam logic [1:0] AGE_OLD = 2'd2;

    typedef logic [DEFAULT_REG_W-1:0]                 reg_idx_t;
    typedef logic [DEFAULT_NUM_SRC*DEFAULT_REG_W-1:0] src_vec_t;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: a pending-write bit plus the age of its producer.
module sb_entry
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    input  logic flush,
    input  logic adv,
    output logic busy,
    output logic busy_d
);

    logic [1:0] age;

    // Set beats clear; a flush only squashes a producer still in EXE.
    always_comb begin
        busy_d = busy;
        if (set) begin
            busy_d = 1'b1;
        end else if (clr || (flush && age == AGE_EXE)) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            age  <= AGE_EXE;
        end else begin
            busy <= busy_d;
            if (set) begin
                age <= AGE_EXE;
            end else if (adv && age != AGE_OLD) begin
                age <= age + 2'd1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks pending long-latency writes and raises ID stalls on true dependencies.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = DEFAULT_NUM_REGS,
    parameter int REG_W       = $clog2(NUM_REGS),
    parameter int NUM_SRC     = 2,
    parameter int WB_BYPASS   = 1,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC*REG_W-1:0]     src_id,
    input  logic [NUM_SRC-1:0]           src_use_id,
    input  logic                         issue_valid,
    input  logic [REG_W-1:0]             issue_rd,
    input  logic                         issue_long,
    input  logic                         wb_valid,
    input  logic [REG_W-1:0]             wb_rd,
    input  logic                         pc_sel_mem,
    output logic                         stall_id,
    output logic                         branch_flush,
    output logic [NUM_REGS-1:0]          busy_vec,
    output logic [$clog2(NUM_REGS+1)-1:0] pending_count,
    output logic                         hazard_timeout
);

    localparam int CNT_W = $clog2(NUM_REGS+1);
    localparam int WD_W  = $clog2(WDOG_CYCLES+1);

    logic [NUM_REGS-1:0] busy_d;
    logic [REG_W-1:0]    src [NUM_SRC];
    logic                eff_issue;
    logic [WD_W-1:0]     wd_cnt;
    logic [WD_W-1:0]     wd_next;
    logic [CNT_W-1:0]    cnt_next;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign src[s] = src_id[s*REG_W +: REG_W];
    end

    // A writeback landing this cycle satisfies the dependency when bypass is on.
    always_comb begin
        stall_id = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_use_id[i] && src[i] != '0 && busy_vec[src[i]] &&
                !(WB_BYPASS != 0 && wb_valid && wb_rd == src[i])) begin
                stall_id = 1'b1;
            end
        end
        if (pc_sel_mem) begin
            stall_id = 1'b0;
        end
    end

    assign branch_flush = pc_sel_mem;
    assign eff_issue    = issue_valid && issue_long && !stall_id && !pc_sel_mem &&
                          issue_rd != '0;

    assign busy_vec[0] = 1'b0;
    assign busy_d[0]   = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry u_entry (
            .clk    (clk),
            .reset  (reset),
            .set    (eff_issue && issue_rd == REG_W'(r)),
            .clr    (wb_valid && wb_rd == REG_W'(r)),
            .flush  (pc_sel_mem),
            .adv    (!stall_id),
            .busy   (busy_vec[r]),
            .busy_d (busy_d[r])
        );
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_next = cnt_next + CNT_W'(busy_d[i]);
        end
    end

    always_comb begin
        wd_next = '0;
        if (stall_id) begin
            wd_next = (wd_cnt == WD_W'(WDOG_CYCLES)) ? wd_cnt : wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt         <= '0;
            pending_count  <= '0;
            hazard_timeout <= 1'b0;
        end else begin
            wd_cnt        <= wd_next;
            pending_count <= cnt_next;
            if (wd_next == WD_W'(WDOG_CYCLES)) begin
                hazard_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic        clk;
    logic        reset;
    src_vec_t    src_id;
    logic [1:0]  src_use_id;
    logic        issue_valid;
    reg_idx_t    issue_rd;
    logic        issue_long;
    logic        wb_valid;
    reg_idx_t    wb_rd;
    logic        pc_sel_mem;
    logic        stall_id;
    logic        branch_flush;
    logic [31:0] busy_vec;
    logic [5:0]  pending_count;
    logic        hazard_timeout;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .src_id         (src_id),
        .src_use_id     (src_use_id),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_long     (issue_long),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .pc_sel_mem     (pc_sel_mem),
        .stall_id       (stall_id),
        .branch_flush   (branch_flush),
        .busy_vec       (busy_vec),
        .pending_count  (pending_count),
        .hazard_timeout (hazard_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src_id      = '0;
        src_use_id  = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_long  = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        pc_sel_mem  = 1'b0;
    endtask

    task automatic drive_issue(input int rd);
        issue_valid = 1'b1;
        issue_long  = 1'b1;
        issue_rd    = reg_idx_t'(rd);
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        total++;
        if (busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'h0); end
        total++;
        if (pending_count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", pending_count); end
        total++;
        if (hazard_timeout !== 1'b0 || stall_id !== 1'b0 || branch_flush !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b%b exp=000", hazard_timeout, stall_id, branch_flush);
        end
        reset = 1'b0;
        #2;
    endtask

    task automatic test_wb_bypass();
        drive_issue(5);
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL bypass_pre_stall got=%b exp=0", stall_id); end
        step();
        total++;
        if (busy_vec !== 32'h20 || pending_count !== 6'd1) begin
            bad++; $display("FAIL bypass_set got=%h/%0d exp=00000020/1", busy_vec, pending_count);
        end
        idle();
        src_id     = src_vec_t'(5);
        src_use_id = 2'b01;
        #1;
        total++;
        if (stall_id !== 1'b1) begin bad++; $display("FAIL bypass_stall got=%b exp=1", stall_id); end
        step();
        wb_valid = 1'b1;
        wb_rd    = reg_idx_t'(5);
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL bypass_wb_stall got=%b exp=0", stall_id); end
        step();
        idle();
        total++;
        if (busy_vec !== 32'h0 || pending_count !== 6'd0) begin
            bad++; $display("FAIL bypass_clear got=%h/%0d exp=00000000/0", busy_vec, pending_count);
        end
    endtask

    task automatic test_flush_young();
        drive_issue(7);
        step();
        idle();
        pc_sel_mem = 1'b1;
        #1;
        total++;
        if (branch_flush !== 1'b1) begin bad++; $display("FAIL flush_out got=%b exp=1", branch_flush); end
        step();
        idle();
        total++;
        if (busy_vec !== 32'h0 || pending_count !== 6'd0) begin
            bad++; $display("FAIL flush_young got=%h/%0d exp=00000000/0", busy_vec, pending_count);
        end
    endtask

    task automatic test_flush_old();
        drive_issue(7);
        step();
        idle();
        step();
        step();
        pc_sel_mem = 1'b1;
        step();
        idle();
        total++;
        if (busy_vec !== 32'h80 || pending_count !== 6'd1) begin
            bad++; $display("FAIL flush_old got=%h/%0d exp=00000080/1", busy_vec, pending_count);
        end
        wb_valid = 1'b1;
        wb_rd    = reg_idx_t'(7);
        step();
        idle();
        total++;
        if (busy_vec !== 32'h0) begin bad++; $display("FAIL flush_old_wb got=%h exp=00000000", busy_vec); end
    endtask

    task automatic test_set_wins();
        drive_issue(9);
        step();
        drive_issue(9);
        wb_valid = 1'b1;
        wb_rd    = reg_idx_t'(9);
        step();
        idle();
        total++;
        if (busy_vec !== 32'h200) begin bad++; $display("FAIL set_wins got=%h exp=00000200", busy_vec); end
        // Age must be back at 0: an immediate flush squashes the entry.
        pc_sel_mem = 1'b1;
        step();
        idle();
        total++;
        if (busy_vec !== 32'h0) begin bad++; $display("FAIL set_wins_age got=%h exp=00000000", busy_vec); end
    endtask

    task automatic test_reg_zero();
        drive_issue(0);
        src_id     = '0;
        src_use_id = 2'b11;
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", stall_id); end
        step();
        idle();
        total++;
        if (busy_vec !== 32'h0 || pending_count !== 6'd0) begin
            bad++; $display("FAIL r0_busy got=%h/%0d exp=00000000/0", busy_vec, pending_count);
        end
    endtask

    task automatic test_back_to_back();
        drive_issue(3);
        step();
        drive_issue(4);
        step();
        drive_issue(6);
        step();
        idle();
        total++;
        if (busy_vec !== 32'h58 || pending_count !== 6'd3) begin
            bad++; $display("FAIL b2b_set got=%h/%0d exp=00000058/3", busy_vec, pending_count);
        end
        src_id     = {reg_idx_t'(4), reg_idx_t'(1)};
        src_use_id = 2'b10;
        #1;
        total++;
        if (stall_id !== 1'b1) begin bad++; $display("FAIL b2b_src1 got=%b exp=1", stall_id); end
        src_use_id = 2'b00;
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL b2b_unused got=%b exp=0", stall_id); end
        src_id     = {reg_idx_t'(0), reg_idx_t'(3)};
        src_use_id = 2'b01;
        wb_valid   = 1'b1;
        wb_rd      = reg_idx_t'(4);
        #1;
        total++;
        if (stall_id !== 1'b1) begin bad++; $display("FAIL b2b_wrong_wb got=%b exp=1", stall_id); end
        pc_sel_mem = 1'b1;
        wb_valid   = 1'b0;
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL b2b_flush_prio got=%b exp=0", stall_id); end
        idle();
        wb_valid = 1'b1;
        wb_rd    = reg_idx_t'(4);
        step();
        wb_rd = reg_idx_t'(3);
        step();
        idle();
        total++;
        if (busy_vec !== 32'h40 || pending_count !== 6'd1) begin
            bad++; $display("FAIL b2b_drain got=%h/%0d exp=00000040/1", busy_vec, pending_count);
        end
        wb_valid = 1'b1;
        wb_rd    = reg_idx_t'(6);
        step();
        idle();
    endtask

    task automatic test_watchdog();
        drive_issue(10);
        step();
        idle();
        src_id     = src_vec_t'(10);
        src_use_id = 2'b01;
        for (int i = 0; i < 254; i++) step();
        total++;
        if (hazard_timeout !== 1'b0 || stall_id !== 1'b1) begin
            bad++; $display("FAIL wdog_early got=%b/%b exp=0/1", hazard_timeout, stall_id);
        end
        step();
        total++;
        if (hazard_timeout !== 1'b1) begin bad++; $display("FAIL wdog_fire got=%b exp=1", hazard_timeout); end
        src_use_id = 2'b00;
        step();
        step();
        total++;
        if (hazard_timeout !== 1'b1) begin bad++; $display("FAIL wdog_sticky got=%b exp=1", hazard_timeout); end
        src_use_id = 2'b01;
        #1;
        total++;
        if (stall_id !== 1'b1) begin bad++; $display("FAIL wdog_restall got=%b exp=1", stall_id); end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (stall_id !== 1'b0 || busy_vec !== 32'h0 || pending_count !== 6'd0 || hazard_timeout !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%b/%h/%0d/%b exp=0/00000000/0/0",
                            stall_id, busy_vec, pending_count, hazard_timeout);
        end
        step();
        reset = 1'b0;
        idle();
        drive_issue(12);
        step();
        idle();
        total++;
        if (busy_vec !== 32'h1000 || pending_count !== 6'd1) begin
            bad++; $display("FAIL post_reset got=%h/%0d exp=00001000/1", busy_vec, pending_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_wb_bypass();
        test_flush_young();
        test_flush_old();
        test_set_wins();
        test_reg_zero();
        test_back_to_back();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
